// File: rtl/reflet_mem_pkg.sv
// Shared definitions for the word-to-byte memory sequencer: state encoding
// and word geometry helper.
package reflet_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    function automatic int bytes_per_word(input int wordsize);
        return wordsize / 8;
    endfunction

endpackage

// File: rtl/reflet_mem_byte_seq.sv
// Splits CPU word accesses into little-endian byte accesses to an 8-bit synchronous RAM.
// Optional misaligned-address trap with cpu_err output: define REFLET_MEM_ALIGN_CHECK_EN.
module reflet_mem_byte_seq
    import reflet_mem_pkg::*;
#(
    parameter int wordsize = 16,
    parameter int addrSize = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_write,
    input  logic [addrSize-1:0] cpu_addr,
    input  logic [wordsize-1:0] cpu_wdata,
    output logic [wordsize-1:0] cpu_rdata,
    output logic                cpu_ready,
    output logic                cpu_busy,
    output logic                ram_enable,
    output logic                ram_write_en,
    output logic [addrSize-1:0] ram_addr,
    output logic [7:0]          ram_data_in,
    input  logic [7:0]          ram_data_out
`ifdef REFLET_MEM_ALIGN_CHECK_EN
    ,
    output logic                cpu_err
`endif
);

    localparam int NB    = bytes_per_word(wordsize);
    localparam int CW    = $clog2(NB + 1);
    localparam int NSLOT = 2 ** CW;
    localparam logic [CW-1:0] C_LAST     = CW'(NB - 1);
    localparam logic [CW-1:0] C_READ_END = CW'(NB);

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;
    logic [addrSize-1:0] r_base;
    logic [wordsize-1:0] r_wdata;
    logic [wordsize-1:0] r_shift;
    logic [wordsize-1:0] r_rdata;
    logic [wordsize-1:0] w_assembled;
    logic [7:0]          w_wbytes [NSLOT];
    logic [CW-1:0]       w_offset;
    logic                w_misaligned;

`ifdef REFLET_MEM_ALIGN_CHECK_EN
    logic r_misaligned;
    assign w_misaligned = (cpu_addr % addrSize'(NB)) != '0;
    assign cpu_err      = (r_state == ST_DONE) && r_misaligned;
`else
    assign w_misaligned = 1'b0;
`endif

    genvar gi;
    // Write byte lanes padded to a power-of-two table so r_cnt indexes it directly.
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_wbytes
            if (gi < NB) begin : g_used
                assign w_wbytes[gi] = r_wdata[gi*8 +: 8];
            end else begin : g_pad
                assign w_wbytes[gi] = 8'h00;
            end
        end
        // RAM data for byte k arrives one cycle after its address, i.e. while r_cnt == k+1.
        for (gi = 0; gi < NB; gi++) begin : g_asm
            assign w_assembled[gi*8 +: 8] =
                (r_cnt == CW'(gi + 1)) ? ram_data_out : r_shift[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (cpu_req) begin
                    if (w_misaligned)   w_state_next = ST_DONE;
                    else if (cpu_write) w_state_next = ST_WRITE;
                    else                w_state_next = ST_READ;
                end
            end
            ST_WRITE: begin
                w_cnt_next = r_cnt + CW'(1);
                if (r_cnt == C_LAST) begin
                    w_state_next = ST_DONE;
                    w_cnt_next   = '0;
                end
            end
            ST_READ: begin
                w_cnt_next = r_cnt + CW'(1);
                if (r_cnt == C_READ_END) begin
                    w_state_next = ST_DONE;
                    w_cnt_next   = '0;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // The final read cycle repeats the last address so the RAM keeps driving its data.
    assign w_offset = (r_state == ST_READ && r_cnt == C_READ_END) ? C_LAST : r_cnt;

    always_comb begin
        ram_enable   = 1'b0;
        ram_write_en = 1'b0;
        ram_addr     = '0;
        ram_data_in  = 8'h00;
        if (r_state == ST_WRITE || r_state == ST_READ) begin
            ram_enable = 1'b1;
            ram_addr   = r_base + addrSize'(w_offset);
        end
        if (r_state == ST_WRITE) begin
            ram_write_en = 1'b1;
            ram_data_in  = w_wbytes[r_cnt];
        end
    end

    assign cpu_ready = (r_state == ST_DONE);
    assign cpu_busy  = (r_state != ST_IDLE);
    assign cpu_rdata = r_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_base  <= '0;
            r_wdata <= '0;
            r_shift <= '0;
            r_rdata <= '0;
`ifdef REFLET_MEM_ALIGN_CHECK_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (r_state == ST_IDLE && cpu_req) begin
                r_base  <= cpu_addr;
                r_wdata <= cpu_wdata;
`ifdef REFLET_MEM_ALIGN_CHECK_EN
                r_misaligned <= w_misaligned;
`endif
            end
            if (r_state == ST_READ) begin
                r_shift <= w_assembled;
                if (r_cnt == C_READ_END) begin
                    r_rdata <= w_assembled;
                end
            end
        end
    end

endmodule

// File: tb/tb_reflet_mem_byte_seq.sv
// Directed bench for reflet_mem_byte_seq (wordsize=16, addrSize=7) with a
// 128-byte synchronous RAM model whose output is gated by enable.
module tb_reflet_mem_byte_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_write = 1'b0;
    logic [6:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_busy;
    logic        ram_enable;
    logic        ram_write_en;
    logic [6:0]  ram_addr;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out;
`ifdef REFLET_MEM_ALIGN_CHECK_EN
    logic        cpu_err;
`endif

    reflet_mem_byte_seq #(.wordsize(16), .addrSize(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_write    (cpu_write),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_ready    (cpu_ready),
        .cpu_busy     (cpu_busy),
        .ram_enable   (ram_enable),
        .ram_write_en (ram_write_en),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
`ifdef REFLET_MEM_ALIGN_CHECK_EN
        ,
        .cpu_err      (cpu_err)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: registered read, output forced to zero while enable is low.
    logic [7:0] mem [0:127];
    logic [7:0] ram_q = 8'h00;
    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_write_en) mem[ram_addr] <= ram_data_in;
            ram_q <= mem[ram_addr];
        end
    end
    assign ram_data_out = ram_enable ? ram_q : 8'h00;

    int         n_cmp = 0;
    int         n_err = 0;
    int         rdy_cyc;
    int         rdy_cnt;
    int         err_cyc;
    logic       en_seen;
    logic [6:0] aseq [1:4];
    logic       rdy_hist [1:12];
    logic       busy_hist [1:12];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, 32'(cpu_rdata), 0);
        chk({tag, "_ready"}, 32'(cpu_ready), 0);
        chk({tag, "_busy"},  32'(cpu_busy), 0);
        chk({tag, "_en"},    32'(ram_enable), 0);
        chk({tag, "_we"},    32'(ram_write_en), 0);
        chk({tag, "_addr"},  32'(ram_addr), 0);
        chk({tag, "_din"},   32'(ram_data_in), 0);
    endtask

    // Issues one request at a negedge, drops it after the accepting edge and
    // observes 8 cycles; cycle c is the c-th negedge after the accepting edge.
    task automatic run_txn(input logic wr, input logic [6:0] addr, input logic [15:0] wd);
        cpu_req   = 1'b1;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        rdy_cyc   = 0;
        rdy_cnt   = 0;
        err_cyc   = 0;
        en_seen   = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) cpu_req = 1'b0;
            if (cpu_ready === 1'b1) begin
                rdy_cnt++;
                if (rdy_cyc == 0) rdy_cyc = c;
            end
`ifdef REFLET_MEM_ALIGN_CHECK_EN
            if (cpu_err === 1'b1 && err_cyc == 0) err_cyc = c;
`endif
            if (ram_enable === 1'b1) en_seen = 1'b1;
            if (c <= 4) aseq[c] = ram_addr;
        end
        $display("txn %s addr=%02h wdata=%04h rdata=%04h ready_cycle=%0d pulses=%0d",
                 wr ? "WR" : "RD", addr, wd, cpu_rdata, rdy_cyc, rdy_cnt);
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(cpu_busy), 0);

        // Write 0xBEEF at 0x10
        run_txn(1'b1, 7'h10, 16'hBEEF);
        chk("wr1_lat", 32'(rdy_cyc), 3);
        chk("wr1_pulses", 32'(rdy_cnt), 1);
        chk("wr1_a1", 32'(aseq[1]), 'h10);
        chk("wr1_a2", 32'(aseq[2]), 'h11);
        chk("wr1_mem10", 32'(mem[7'h10]), 'hEF);
        chk("wr1_mem11", 32'(mem[7'h11]), 'hBE);
        chk("wr1_rdata_kept", 32'(cpu_rdata), 0);

        // Read it back
        run_txn(1'b0, 7'h10, 16'h0000);
        chk("rd1_lat", 32'(rdy_cyc), 4);
        chk("rd1_pulses", 32'(rdy_cnt), 1);
        chk("rd1_rdata", 32'(cpu_rdata), 'hBEEF);
        chk("rd1_a1", 32'(aseq[1]), 'h10);
        chk("rd1_a2", 32'(aseq[2]), 'h11);
        chk("rd1_a3", 32'(aseq[3]), 'h11);

        // Wrap-around write at 0x7F, then read back
        run_txn(1'b1, 7'h7F, 16'h1234);
        chk("wr2_mem7f", 32'(mem[7'h7F]), 'h34);
        chk("wr2_mem00", 32'(mem[7'h00]), 'h12);
        chk("wr2_rdata_kept", 32'(cpu_rdata), 'hBEEF);
        chk("wr2_a2", 32'(aseq[2]), 'h00);
        run_txn(1'b0, 7'h7F, 16'h0000);
        chk("rd2_rdata", 32'(cpu_rdata), 'h1234);
        chk("rd2_a3", 32'(aseq[3]), 'h00);
        chk("rd2_lat", 32'(rdy_cyc), 4);

        // Reset during the READ cnt=1 cycle
        cpu_req   = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = 7'h10;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("abort_pre_addr", 32'(ram_addr), 'h11);
        #1 reset = 1'b0;
        #1 chk_all_zero("abort");
        rdy_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ready === 1'b1) rdy_cnt++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ready === 1'b1) rdy_cnt++;
        end
        chk("abort_no_ready", 32'(rdy_cnt), 0);
        $display("txn RST abort during read, ready pulses after=%0d", rdy_cnt);
        run_txn(1'b0, 7'h10, 16'h0000);
        chk("rd3_rdata", 32'(cpu_rdata), 'hBEEF);
        chk("rd3_lat", 32'(rdy_cyc), 4);

        // cpu_req held: write 0xA55A at 0x20 then read it back-to-back
        cpu_req   = 1'b1;
        cpu_write = 1'b1;
        cpu_addr  = 7'h20;
        cpu_wdata = 16'hA55A;
        rdy_cnt   = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) cpu_write = 1'b0;
            if (c == 5) cpu_req = 1'b0;
            rdy_hist[c]  = cpu_ready;
            busy_hist[c] = cpu_busy;
            if (cpu_ready === 1'b1) rdy_cnt++;
        end
        chk("b2b_wr_ready_c3", 32'(rdy_hist[3]), 1);
        chk("b2b_busy_done_c3", 32'(busy_hist[3]), 1);
        chk("b2b_idle_c4", 32'(busy_hist[4]), 0);
        chk("b2b_rd_ready_c8", 32'(rdy_hist[8]), 1);
        chk("b2b_pulses", 32'(rdy_cnt), 2);
        chk("b2b_rdata", 32'(cpu_rdata), 'hA55A);
        chk("b2b_mem20", 32'(mem[7'h20]), 'h5A);
        chk("b2b_mem21", 32'(mem[7'h21]), 'hA5);
        $display("txn WR+RD held req addr=20 rdata=%04h pulses=%0d", cpu_rdata, rdy_cnt);

`ifdef REFLET_MEM_ALIGN_CHECK_EN
        // Misaligned read traps without touching the RAM
        run_txn(1'b0, 7'h11, 16'h0000);
        chk("mis_ready_cyc", 32'(rdy_cyc), 1);
        chk("mis_err_cyc", 32'(err_cyc), 1);
        chk("mis_pulses", 32'(rdy_cnt), 1);
        chk("mis_no_ram", 32'(en_seen), 0);
        chk("mis_rdata_kept", 32'(cpu_rdata), 'hA55A);
        chk("mis_err_low", 32'(cpu_err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
